// File: rtl/dds_sequencer.sv
// Sequencer stepping a shared instruction address with per-instruction dwell, optional start delay,
// looping and MEM_LAT-aligned per-channel valid pulses. Define DDS_SEQ_PAUSE_EN to enable pause.
module dds_sequencer #(
    parameter int ADDR_W    = 17,
    parameter int NUM_CH    = 2,
    parameter int NUM_INSTR = 66583,
    parameter int DWELL_W   = 16,
    parameter int DELAY_W   = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic               pause,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DELAY_W-1:0] start_delay,
    input  logic [NUM_CH-1:0]  ch_en,
    output logic [ADDR_W-1:0]  addr,
    output logic [NUM_CH-1:0]  ch_valid,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pass_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_INSTR - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DWELL_W-1:0]  dwell_cnt_q;
    logic [DELAY_W-1:0]  dly_cnt_q;
    logic [15:0]         pass_q;
    logic [NUM_CH-1:0]   ch_en_q;
    logic [MEM_LAT:0]    vld_pipe_q;
    logic                busy_q, done_q;

    logic frz;
`ifdef DDS_SEQ_PAUSE_EN
    assign frz = pause;
`else
    logic unused_pause;
    assign frz          = 1'b0;
    assign unused_pause = pause;
`endif

    logic start_ok, dly_end, dwell_end, last, stb_d;
    assign start_ok  = start && !stop && (state_q == S_IDLE || state_q == S_DONE);
    assign dly_end   = (state_q == S_DELAY) && !frz && (dly_cnt_q == '0);
    assign dwell_end = (state_q == S_RUN) && !frz && (dwell_cnt_q == '0);
    assign last      = (addr_q == LAST);
    // One strobe per newly presented address: RUN entry, increment or wrap.
    assign stb_d     = !stop && ((start_ok && start_delay == '0) || dly_end ||
                                 (dwell_end && (!last || loop_en)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            dwell_cnt_q <= '0;
            dly_cnt_q   <= '0;
            pass_q      <= '0;
            ch_en_q     <= '0;
            vld_pipe_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vld_pipe_q <= stop ? '0 : (MEM_LAT+1)'({vld_pipe_q, stb_d});
            if (stop) begin
                state_q <= S_IDLE;
                addr_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_ok) begin
                            pass_q  <= '0;
                            ch_en_q <= ch_en;
                            addr_q  <= '0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            if (start_delay != '0) begin
                                state_q   <= S_DELAY;
                                dly_cnt_q <= start_delay - DELAY_W'(1);
                            end else begin
                                state_q     <= S_RUN;
                                dwell_cnt_q <= dwell;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (!frz) begin
                            if (dly_end) begin
                                state_q     <= S_RUN;
                                dwell_cnt_q <= dwell;
                            end else begin
                                dly_cnt_q <= dly_cnt_q - DELAY_W'(1);
                            end
                        end
                    end
                    S_RUN: begin
                        if (!frz) begin
                            if (dwell_end) begin
                                if (!last) begin
                                    addr_q      <= addr_q + ADDR_W'(1);
                                    dwell_cnt_q <= dwell;
                                end else begin
                                    if (pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
                                    if (loop_en) begin
                                        addr_q      <= '0;
                                        dwell_cnt_q <= dwell;
                                    end else begin
                                        state_q <= S_DONE;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end
                                end
                            end else begin
                                dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign addr     = addr_q;
    assign ch_valid = vld_pipe_q[MEM_LAT] ? ch_en_q : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_dds_sequencer.sv
// Bench for dds_sequencer: two configurations (4 instr / latency 2, 3 instr / latency 0)
// driven in lockstep and checked every cycle against a cycle-level reference model.
module tb_dds_sequencer;

`ifdef DDS_SEQ_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, stop, loop_en, pause;
    logic [15:0] dwell;
    logic [7:0]  start_delay;
    logic [1:0]  ch_en;
    logic [2:0]  addr0;
    logic [1:0]  addr1;
    logic [1:0]  cv0, cv1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] pc0, pc1;

    always #5 clk = ~clk;

    dds_sequencer #(.ADDR_W(3), .NUM_CH(2), .NUM_INSTR(4), .DWELL_W(16), .DELAY_W(8), .MEM_LAT(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en), .pause(pause),
        .dwell(dwell), .start_delay(start_delay), .ch_en(ch_en),
        .addr(addr0), .ch_valid(cv0), .busy(busy0), .done(done0), .pass_cnt(pc0));

    dds_sequencer #(.ADDR_W(2), .NUM_CH(2), .NUM_INSTR(3), .DWELL_W(16), .DELAY_W(8), .MEM_LAT(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en), .pause(pause),
        .dwell(dwell), .start_delay(start_delay), .ch_en(ch_en),
        .addr(addr1), .ch_valid(cv1), .busy(busy1), .done(done1), .pass_cnt(pc1));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 delay, 2 run, 3 done; hist[i] = address presented i cycles ago.
    int NI[2] = '{4, 3};
    int ML[2] = '{2, 0};
    int m_st[2], m_addr[2], m_dly[2], m_left[2], m_pass[2], m_chen[2];
    bit m_hist[2][5];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_addr[k] = 0; m_dly[k] = 0; m_left[k] = 0; m_pass[k] = 0; m_chen[k] = 0;
            for (int i = 0; i < 5; i++) m_hist[k][i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit pz;
        pz = PAUSE_ON && pause;
        for (int k = 0; k < 2; k++) begin
            for (int i = 4; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = 1'b0;
            if (stop) begin
                m_st[k] = 0; m_addr[k] = 0;
                for (int i = 0; i < 5; i++) m_hist[k][i] = 1'b0;
            end else if (m_st[k] == 0 || m_st[k] == 3) begin
                if (start) begin
                    m_pass[k] = 0; m_chen[k] = ch_en; m_addr[k] = 0;
                    if (start_delay > 0) begin
                        m_st[k] = 1; m_dly[k] = start_delay;
                    end else begin
                        m_st[k] = 2; m_left[k] = dwell + 1; m_hist[k][0] = 1'b1;
                    end
                end
            end else if (m_st[k] == 1) begin
                if (!pz) begin
                    m_dly[k]--;
                    if (m_dly[k] == 0) begin
                        m_st[k] = 2; m_left[k] = dwell + 1; m_hist[k][0] = 1'b1;
                    end
                end
            end else if (!pz) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    if (m_addr[k] < NI[k] - 1) begin
                        m_addr[k]++; m_left[k] = dwell + 1; m_hist[k][0] = 1'b1;
                    end else begin
                        if (m_pass[k] < 65535) m_pass[k]++;
                        if (loop_en) begin
                            m_addr[k] = 0; m_left[k] = dwell + 1; m_hist[k][0] = 1'b1;
                        end else m_st[k] = 3;
                    end
                end
            end
        end
    endtask

    function automatic int exp_cv(input int k);
        return m_hist[k][ML[k]] ? m_chen[k] : 0;
    endfunction

    task automatic check_all();
        chk("addr0", addr0, m_addr[0]);
        chk("addr1", addr1, m_addr[1]);
        chk("ch_valid0", cv0, exp_cv(0));
        chk("ch_valid1", cv1, exp_cv(1));
        chk("busy0", busy0, (m_st[0] == 1 || m_st[0] == 2));
        chk("busy1", busy1, (m_st[1] == 1 || m_st[1] == 2));
        chk("done0", done0, (m_st[0] == 3));
        chk("done1", done1, (m_st[1] == 3));
        chk("pass0", pc0, m_pass[0]);
        chk("pass1", pc1, m_pass[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic launch(input int sd, input int dw, input bit le, input logic [1:0] ce);
        start_delay = 8'(sd); dwell = 16'(dw); loop_en = le; ch_en = ce;
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic wait_addr0(input int val);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (addr0 == 3'(val)) found = 1'b1;
        end
        if (!found) chk("wait_addr0_timeout", 0, 1);
    endtask

    typedef struct {
        int sd; int dw; bit le; int n;
        int a0; int p0; bit d0;
        int a1; int p1; bit d1;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, first;
        bit bad0, any_cv;

        tbl[0] = '{0, 2, 0, 11, 3, 0, 0, 2, 1, 1};
        tbl[1] = '{0, 2, 0, 12, 3, 1, 1, 2, 1, 1};
        tbl[2] = '{5, 0, 0, 6,  1, 0, 0, 1, 0, 0};
        tbl[3] = '{5, 0, 0, 9,  3, 1, 1, 2, 1, 1};
        tbl[4] = '{0, 0, 1, 10, 2, 2, 0, 1, 3, 0};
        tbl[5] = '{3, 1, 1, 13, 1, 1, 0, 2, 1, 0};

        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; pause = 1'b0;
        dwell = '0; start_delay = '0; ch_en = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk); reset = 1'b0;
        repeat (3) cycle();

        // Table: final state after n cycles past the start edge.
        foreach (tbl[v]) begin
            do_stop();
            launch(tbl[v].sd, tbl[v].dw, tbl[v].le, 2'b11);
            repeat (tbl[v].n) cycle();
            chk($sformatf("tbl%0d_addr0", v), addr0, tbl[v].a0);
            chk($sformatf("tbl%0d_pass0", v), pc0, tbl[v].p0);
            chk($sformatf("tbl%0d_done0", v), done0, tbl[v].d0);
            chk($sformatf("tbl%0d_addr1", v), addr1, tbl[v].a1);
            chk($sformatf("tbl%0d_pass1", v), pc1, tbl[v].p1);
            chk($sformatf("tbl%0d_done1", v), done1, tbl[v].d1);
        end

        // Delay 5, latency 2, only channel 1 enabled.
        do_stop();
        launch(5, 0, 0, 2'b10);
        first = -1; bad0 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (cv0 != 0 && first < 0) begin
                first = i;
                chk("lat_cv0_value", cv0, 2'b10);
            end
            if (cv0[0]) bad0 = 1'b1;
        end
        chk("lat_first_valid_edge", first, 7);
        chk("lat_ch0_never", bad0, 0);

        // Stop and start together while running at addr 2.
        do_stop();
        launch(0, 0, 1, 2'b11);
        wait_addr0(2);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        chk("stopstart_addr0", addr0, 0);
        chk("stopstart_busy0", busy0, 0);
        any_cv = (cv0 != 0) || (cv1 != 0);
        repeat (5) begin
            cycle();
            if (cv0 != 0 || cv1 != 0) any_cv = 1'b1;
        end
        chk("stopstart_no_valid", any_cv, 0);

        // Pause held 10 cycles at addr 1 with dwell 3.
        do_stop();
        launch(0, 3, 0, 2'b11);
        wait_addr0(1);
        cnt = 1;
        pause = 1'b1;
        repeat (10) begin cycle(); if (addr0 == 3'd1) cnt++; end
        pause = 1'b0;
        repeat (10) begin cycle(); if (addr0 == 3'd1) cnt++; end
        chk("pause_hold_cycles", cnt, PAUSE_ON ? 14 : 4);

        // Asynchronous reset mid-run at addr 2.
        do_stop();
        launch(0, 1, 1, 2'b11);
        wait_addr0(2);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk); @(negedge clk); reset = 1'b0;
        repeat (5) cycle();
        chk("post_reset_idle_busy0", busy0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            start       = ($urandom % 8) == 0;
            stop        = ($urandom % 40) == 0;
            loop_en     = $urandom % 2;
            pause       = ($urandom % 4) == 0;
            dwell       = 16'($urandom % 4);
            start_delay = 8'($urandom % 5);
            ch_en       = 2'($urandom % 4);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
